// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage RV32M multiply/divide unit.
// Holds funct3 op codes, the M-extension funct7, FSM states and iteration count.
package ex_muldiv_pkg;

    localparam int         ITER_COUNT    = 32;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_sign_fix.sv
// Conditional two's-complement negation: operand magnitude on the way in,
// sign restoration of product/quotient/remainder on the way out. Pure combinational.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: 33-cycle fixed latency, 1 cycle for divide special cases.
// Holds the pipeline via stall_o while busy; flush or reset abandons the op without a done pulse.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      wr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      wr_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q;
    state_t            state_d;
    logic [5:0]        cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic [2:0]        f3_q;
    logic              neg_lo_q;
    logic              neg_rem_q;
    logic [4:0]        wr_q;

    logic              accept;
    logic              last_iter;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;

    assign accept    = start_i & ~flush_i;
    assign last_iter = (cnt_q == 6'(ITER_COUNT - 1));

    // Input side: both operands reduced to magnitudes before iterating
    assign a_neg = rs1_signed(funct3_i) & op_a_i[XLEN-1];
    assign b_neg = rs2_signed(funct3_i) & op_b_i[XLEN-1];

    muldiv_sign_fix #(.W(XLEN)) u_mag_a (.val(op_a_i), .neg(a_neg), .res(a_mag));
    muldiv_sign_fix #(.W(XLEN)) u_mag_b (.val(op_b_i), .neg(b_neg), .res(b_mag));

    assign div_zero = funct3_i[2] && (op_b_i == '0);
    assign div_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                      (op_a_i == INT_MIN) && (op_b_i == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = funct3_i[1] ? op_a_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : INT_MIN;
        end
    end

    // One iteration step. Multiply: acc = {partial, multiplier} shifting right.
    // Divide: acc = {remainder, dividend/quotient} shifting left.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] mul_nxt;
    logic [2*XLEN-1:0] div_nxt;
    logic [2*XLEN-1:0] acc_nxt;

    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

    assign rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    assign rem_ge  = rem_sh >= {1'b0, opb_q};
    assign rem_sub = rem_sh[XLEN-1:0] - opb_q;
    assign div_nxt = rem_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                            : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    assign acc_nxt = f3_q[2] ? div_nxt : mul_nxt;

    // Output side: sign applied to the value the final iteration produces
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   qr_raw;
    logic              qr_neg;
    logic [XLEN-1:0]   qr_fix;
    logic [XLEN-1:0]   final_res;

    assign qr_raw = f3_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    assign qr_neg = f3_q[1] ? neg_rem_q : neg_lo_q;

    muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (.val(acc_nxt), .neg(neg_lo_q), .res(prod_fix));
    muldiv_sign_fix #(.W(XLEN))   u_fix_qr   (.val(qr_raw),  .neg(qr_neg),   .res(qr_fix));

    always_comb begin
        final_res = qr_fix;
        case (f3_q)
            F3_MUL:                       final_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            default:                      final_res = qr_fix;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stall_o = 1'b1;
                    state_d = special ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (last_iter) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_o  = ~flush_i;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // start_i may be high while reset is held; never stall the pipe then
        if (reset) begin
            stall_o = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            f3_q      <= '0;
            neg_lo_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            wr_q      <= '0;
            result_o  <= '0;
            wr_o      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        f3_q      <= funct3_i;
                        wr_q      <= wr_i;
                        opb_q     <= b_mag;
                        neg_lo_q  <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        cnt_q     <= '0;
                        acc_q     <= {{XLEN{1'b0}}, a_mag};
                        if (special) begin
                            result_o <= special_res;
                            wr_o     <= wr_i;
                        end
                    end
                end
                ST_BUSY: begin
                    if (flush_i) begin
                        cnt_q <= '0;
                    end else begin
                        acc_q <= acc_nxt;
                        if (last_iter) begin
                            cnt_q    <= '0;
                            result_o <= final_res;
                            wr_o     <= wr_q;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, flush/reset sequences,
// and randomized ops against an arithmetic reference model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [4:0]  wr_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  wr_o;

    int n_total = 0;
    int n_pass  = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .wr_i     (wr_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .wr_o     (wr_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 19;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV32M arithmetic rules
    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            F3_MUL:    return a * b;
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            default: begin
                if (b == 32'd0) return f3[1] ? a : 32'hFFFFFFFF;
                if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF)
                    return f3[1] ? 32'd0 : 32'h80000000;
                case (f3)
                    F3_DIV:  return ia / ib;
                    F3_REM:  return ia % ib;
                    F3_DIVU: return a / b;
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        if (f3[2] && (b == 32'd0)) return 1;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, scramble inputs afterwards, and observe the response
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wr, output logic [31:0] res, output logic [4:0] wro,
                         output int lat, output int stalls, output int dones,
                         output logic [31:0] hold);
        lat = -1; stalls = 0; dones = 0; res = '0; wro = '0; hold = '0;
        @(negedge clk);
        start_i = 1'b1; funct3_i = f3; op_a_i = a; op_b_i = b; wr_i = wr; flush_i = 1'b0;
        #1;
        if (stall_o) stalls++;
        @(posedge clk); #1;
        start_i = 1'b0; funct3_i = 3'($urandom); op_a_i = $urandom; op_b_i = $urandom;
        wr_i = 5'($urandom);
        for (int n = 1; n <= 40; n++) begin
            if (stall_o) stalls++;
            if (done_o) begin
                dones++;
                if (lat < 0) begin
                    lat = n; res = result_o; wro = wr_o;
                end
            end
            if (lat >= 0 && n == lat + 1) begin
                hold = result_o;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t        vecs [NV];
        logic [31:0] res;
        logic [31:0] hold;
        logic [4:0]  wro;
        int          lat;
        int          stalls;
        int          dones;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rwr;

        vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[2]  = '{F3_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 33};
        vecs[3]  = '{F3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
        vecs[4]  = '{F3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
        vecs[5]  = '{F3_DIVU,   32'd100,        32'd7,        32'd14,       33};
        vecs[6]  = '{F3_REMU,   32'd100,        32'd7,        32'd2,        33};
        vecs[7]  = '{F3_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1};
        vecs[8]  = '{F3_REM,    32'd5,          32'd0,        32'd5,        1};
        vecs[9]  = '{F3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        vecs[10] = '{F3_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
        vecs[11] = '{F3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[12] = '{F3_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vecs[13] = '{F3_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        33};
        vecs[14] = '{F3_DIVU,   32'h80000000,   32'hFFFFFFFF, 32'd0,        33};
        vecs[15] = '{F3_MUL,    32'h80000000,   32'h80000000, 32'd0,        33};
        vecs[16] = '{F3_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33};
        vecs[17] = '{F3_MULHSU, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 33};
        vecs[18] = '{F3_DIV,    32'd0,          32'd0,        32'hFFFFFFFF, 1};

        reset = 1'b1; start_i = 1'b1; flush_i = 1'b0; funct3_i = F3_MUL;
        op_a_i = 32'd9; op_b_i = 32'd9; wr_i = 5'd4;
        @(posedge clk); #1;
        check("rst_stall",  64'(stall_o),  64'(0));
        check("rst_done",   64'(done_o),   64'(0));
        check("rst_result", 64'(result_o), 64'(0));
        check("rst_wr",     64'(wr_o),     64'(0));
        @(negedge clk);
        start_i = 1'b0; reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), res, wro, lat, stalls, dones, hold);
            check($sformatf("v%0d_result", i), 64'(res),    64'(vecs[i].exp));
            check($sformatf("v%0d_latency", i), 64'(lat),   64'(vecs[i].lat));
            check($sformatf("v%0d_wr", i),     64'(wro),    64'(i + 1));
            check($sformatf("v%0d_stalls", i), 64'(stalls), 64'((vecs[i].lat == 33) ? 33 : 1));
            check($sformatf("v%0d_dones", i),  64'(dones),  64'(1));
            check($sformatf("v%0d_hold", i),   64'(hold),   64'(vecs[i].exp));
        end

        // Flush a divide at busy cycle 10, then a fresh multiply right after
        @(negedge clk);
        start_i = 1'b1; funct3_i = F3_DIV; op_a_i = 32'd1000; op_b_i = 32'd3; wr_i = 5'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush_i = 1'b1; #1;
        check("flush_busy_stall", 64'(stall_o), 64'(0));
        check("flush_busy_done",  64'(done_o),  64'(0));
        @(posedge clk); #1;
        flush_i = 1'b0; #1;
        check("flush_idle_stall", 64'(stall_o), 64'(0));
        check("flush_idle_done",  64'(done_o),  64'(0));
        do_op(F3_MUL, 32'd3, 32'd4, 5'd12, res, wro, lat, stalls, dones, hold);
        check("post_flush_result",  64'(res), 64'(12));
        check("post_flush_latency", 64'(lat), 64'(33));
        check("post_flush_wr",      64'(wro), 64'(12));

        // Flush while in DONE suppresses the pulse
        @(negedge clk);
        start_i = 1'b1; funct3_i = F3_DIVU; op_a_i = 32'd5; op_b_i = 32'd0; wr_i = 5'd3;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b1; #1;
        check("flush_done_pulse", 64'(done_o),  64'(0));
        check("flush_done_stall", 64'(stall_o), 64'(0));
        @(posedge clk); #1;
        flush_i = 1'b0; #1;
        check("flush_done_after", 64'(done_o), 64'(0));

        // Reset at busy cycle 20 with start_i held across release
        @(negedge clk);
        start_i = 1'b1; funct3_i = F3_MUL; op_a_i = 32'h12345; op_b_i = 32'h777; wr_i = 5'd21;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        start_i = 1'b1; funct3_i = F3_MUL; op_a_i = 32'd5; op_b_i = 32'd6; wr_i = 5'd9;
        #1;
        check("midrst_stall",  64'(stall_o),  64'(0));
        check("midrst_done",   64'(done_o),   64'(0));
        check("midrst_result", 64'(result_o), 64'(0));
        check("midrst_wr",     64'(wr_o),     64'(0));
        @(posedge clk); #1;
        reset = 1'b0; #1;
        check("midrst_release_stall", 64'(stall_o), 64'(1));
        do_op(F3_MUL, 32'd5, 32'd6, 5'd9, res, wro, lat, stalls, dones, hold);
        check("midrst_new_result",  64'(res), 64'(30));
        check("midrst_new_latency", 64'(lat), 64'(33));
        check("midrst_new_wr",      64'(wro), 64'(9));

        for (int k = 0; k < 200; k++) begin
            rf3 = 3'($urandom);
            ra  = pick_operand();
            rb  = pick_operand();
            rwr = 5'($urandom);
            do_op(rf3, ra, rb, rwr, res, wro, lat, stalls, dones, hold);
            check($sformatf("rnd%0d_f3_%0d_%h_%h_result", k, rf3, ra, rb), 64'(res),
                  64'(model_res(rf3, ra, rb)));
            check($sformatf("rnd%0d_latency", k), 64'(lat), 64'(model_lat(rf3, ra, rb)));
            check($sformatf("rnd%0d_wr", k), 64'(wro), 64'(rwr));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
